// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch (IF) and load/store (DM).
// Define ARB_PERF_CNT_EN to build the IDLE-contention counter on conf_cnt_o (tied to 0 otherwise).
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | no access in flight; grants are decided combinationally here
//  BUSY_IF | fetch access in flight, mem_en held for MEM_LAT cycles
//  BUSY_DM | load/store access in flight, mem_en held for MEM_LAT cycles
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_LAT       = 1,
    parameter int IF_STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                stall_if_o,
    output logic                stall_dm_o,
    output logic [31:0]         conf_cnt_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(IF_STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(IF_STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    state_e              state_q;
    logic [LAT_W-1:0]    lat_cnt_q;
    logic [STV_W-1:0]    starve_cnt_q;
    logic [STV_W-1:0]    starve_cnt_d;
    logic                if_rvalid_q;
    logic                dm_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [BE_W-1:0]     mem_be_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic idle;
    logic starve_hit;
    logic if_gnt;
    logic dm_gnt;

    // DM is the older instruction and normally wins, unless IF has waited out its budget.
    assign idle       = (state_q == IDLE);
    assign starve_hit = (starve_cnt_q == STV_MAX);
    assign if_gnt     = idle & if_req_i & (~dm_req_i | starve_hit);
    assign dm_gnt     = idle & dm_req_i & ~(if_req_i & starve_hit);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_i || if_gnt) begin
            starve_cnt_d = '0;
        end else if (dm_gnt && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    lat_cnt_q <= '0;
                    if (if_gnt) begin
                        state_q     <= BUSY_IF;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '1;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= '0;
                    end else if (dm_gnt) begin
                        state_q     <= BUSY_DM;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= dm_we_i;
                        mem_be_q    <= dm_we_i ? dm_be_i : '1;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_we_i ? dm_wdata_i : '0;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        state_q     <= IDLE;
                        lat_cnt_q   <= '0;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        if (state_q == BUSY_IF) begin
                            if_rdata_q  <= mem_rdata_i;
                            if_rvalid_q <= 1'b1;
                        end else begin
                            // a completed store returns zero, never stale memory contents
                            dm_rdata_q  <= mem_we_q ? '0 : mem_rdata_i;
                            dm_rvalid_q <= 1'b1;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conf_cnt_q;
    logic [31:0] conf_cnt_d;

    always_comb begin
        conf_cnt_d = conf_cnt_q;
        if (if_req_i && dm_req_i && idle && (conf_cnt_q != 32'hFFFF_FFFF)) begin
            conf_cnt_d = conf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conf_cnt_q <= '0;
        end else begin
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign conf_cnt_o = conf_cnt_q;
`else
    assign conf_cnt_o = 32'h0;
`endif

    assign if_gnt_o    = if_gnt;
    assign dm_gnt_o    = dm_gnt;
    assign if_rvalid_o = if_rvalid_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign stall_if_o  = if_req_i & ~if_rvalid_q;
    assign stall_dm_o  = dm_req_i & ~dm_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter at MEM_LAT = 1, 2 and 3.
// Instance g runs with MEM_LAT = g+1; conf_cnt expectations follow ARB_PERF_CNT_EN.
module tb_mem_port_arbiter;

    localparam int N_DUT = 3;
`ifdef ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [N_DUT];
    logic        if_req    [N_DUT];
    logic [31:0] if_addr   [N_DUT];
    logic        if_gnt    [N_DUT];
    logic        if_rvalid [N_DUT];
    logic [31:0] if_rdata  [N_DUT];
    logic        dm_req    [N_DUT];
    logic        dm_we     [N_DUT];
    logic [3:0]  dm_be     [N_DUT];
    logic [31:0] dm_addr   [N_DUT];
    logic [31:0] dm_wdata  [N_DUT];
    logic        dm_gnt    [N_DUT];
    logic        dm_rvalid [N_DUT];
    logic [31:0] dm_rdata  [N_DUT];
    logic        mem_en    [N_DUT];
    logic        mem_we    [N_DUT];
    logic [3:0]  mem_be    [N_DUT];
    logic [31:0] mem_addr  [N_DUT];
    logic [31:0] mem_wdata [N_DUT];
    logic [31:0] mem_rdata [N_DUT];
    logic        stall_if  [N_DUT];
    logic        stall_dm  [N_DUT];
    logic [31:0] conf_cnt  [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1), .IF_STARVE_MAX(4)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n[g]),
            .if_req_i(if_req[g]), .if_addr_i(if_addr[g]), .if_gnt_o(if_gnt[g]),
            .if_rvalid_o(if_rvalid[g]), .if_rdata_o(if_rdata[g]),
            .dm_req_i(dm_req[g]), .dm_we_i(dm_we[g]), .dm_be_i(dm_be[g]),
            .dm_addr_i(dm_addr[g]), .dm_wdata_i(dm_wdata[g]), .dm_gnt_o(dm_gnt[g]),
            .dm_rvalid_o(dm_rvalid[g]), .dm_rdata_o(dm_rdata[g]),
            .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_be_o(mem_be[g]),
            .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g]),
            .stall_if_o(stall_if[g]), .stall_dm_o(stall_dm[g]), .conf_cnt_o(conf_cnt[g])
        );
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    int k;
    bit exp_if;
    bit prev_if;

    initial begin
        for (int i = 0; i < N_DUT; i++) begin
            rst_n[i] = 1'b0;  if_req[i] = 1'b0;  if_addr[i] = '0;
            dm_req[i] = 1'b0; dm_we[i] = 1'b0;   dm_be[i] = '0;
            dm_addr[i] = '0;  dm_wdata[i] = '0;  mem_rdata[i] = '0;
        end

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            chk("rst_mem_en", 32'(mem_en[i]), 32'd0);
            chk("rst_mem_be", 32'(mem_be[i]), 32'd0);
            chk("rst_if_rvalid", 32'(if_rvalid[i]), 32'd0);
            chk("rst_dm_rvalid", 32'(dm_rvalid[i]), 32'd0);
            chk("rst_conf_cnt", conf_cnt[i], 32'd0);
        end
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) rst_n[i] = 1'b1;

        // single fetch, MEM_LAT=1
        @(negedge clk); if_req[0] = 1'b1; if_addr[0] = 32'h40; #1;
        chk("t2_if_gnt", 32'(if_gnt[0]), 32'd1);
        chk("t2_dm_gnt", 32'(dm_gnt[0]), 32'd0);
        chk("t2_mem_en_n", 32'(mem_en[0]), 32'd0);
        chk("t2_stall_if", 32'(stall_if[0]), 32'd1);
        @(negedge clk); if_req[0] = 1'b0; if_addr[0] = 32'hFFFF_FFFC; mem_rdata[0] = 32'h0050_0093; #1;
        chk("t2_mem_en", 32'(mem_en[0]), 32'd1);
        chk("t2_mem_addr", mem_addr[0], 32'h40);
        chk("t2_mem_we", 32'(mem_we[0]), 32'd0);
        chk("t2_mem_be", 32'(mem_be[0]), 32'hF);
        @(negedge clk); mem_rdata[0] = '0; #1;
        chk("t2_if_rvalid", 32'(if_rvalid[0]), 32'd1);
        chk("t2_if_rdata", if_rdata[0], 32'h0050_0093);
        chk("t2_dm_rvalid", 32'(dm_rvalid[0]), 32'd0);
        chk("t2_mem_en_done", 32'(mem_en[0]), 32'd0);
        @(negedge clk); #1;
        chk("t2_if_rvalid_pulse", 32'(if_rvalid[0]), 32'd0);

        // store, MEM_LAT=1
        @(negedge clk);
        dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_be[0] = 4'b0011;
        dm_addr[0] = 32'h100; dm_wdata[0] = 32'hDEAD_BEEF; #1;
        chk("t3_dm_gnt", 32'(dm_gnt[0]), 32'd1);
        chk("t3_if_gnt", 32'(if_gnt[0]), 32'd0);
        chk("t3_stall_dm", 32'(stall_dm[0]), 32'd1);
        @(negedge clk);
        dm_req[0] = 1'b0; dm_we[0] = 1'b0; dm_be[0] = '0; dm_addr[0] = '0; dm_wdata[0] = '0;
        mem_rdata[0] = 32'h1234_5678; #1;
        chk("t3_mem_en", 32'(mem_en[0]), 32'd1);
        chk("t3_mem_we", 32'(mem_we[0]), 32'd1);
        chk("t3_mem_be", 32'(mem_be[0]), 32'h3);
        chk("t3_mem_addr", mem_addr[0], 32'h100);
        chk("t3_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
        @(negedge clk); mem_rdata[0] = '0; #1;
        chk("t3_dm_rvalid", 32'(dm_rvalid[0]), 32'd1);
        chk("t3_dm_rdata", dm_rdata[0], 32'd0);
        chk("t3_mem_we_done", 32'(mem_we[0]), 32'd0);
        chk("t3_if_rvalid", 32'(if_rvalid[0]), 32'd0);

        // both requesting, MEM_LAT=1: DM x4, IF, DM x4, IF
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if_req[0] = 1'b1; dm_req[0] = 1'b1; dm_we[0] = 1'b0;
            if_addr[0] = 32'h200; dm_addr[0] = 32'h300;
            mem_rdata[0] = 32'hB000_0000 + 32'(i); #1;
            k = i / 2;
            exp_if = (k == 4) || (k == 9);
            if (i % 2 == 0) begin
                chk("t4_if_gnt", 32'(if_gnt[0]), 32'(exp_if));
                chk("t4_dm_gnt", 32'(dm_gnt[0]), 32'(!exp_if));
                if (i > 0) begin
                    prev_if = (k - 1 == 4);
                    chk("t4_if_rvalid", 32'(if_rvalid[0]), 32'(prev_if));
                    chk("t4_dm_rvalid", 32'(dm_rvalid[0]), 32'(!prev_if));
                    chk("t4_rdata", prev_if ? if_rdata[0] : dm_rdata[0], 32'hB000_0000 + 32'(i - 1));
                end
            end else begin
                chk("t4_busy_gnt", 32'(if_gnt[0] | dm_gnt[0]), 32'd0);
                chk("t4_mem_en", 32'(mem_en[0]), 32'd1);
                chk("t4_mem_addr", mem_addr[0], exp_if ? 32'h200 : 32'h300);
                chk("t4_stall_if", 32'(stall_if[0]), 32'd1);
            end
        end
        @(negedge clk); if_req[0] = 1'b0; dm_req[0] = 1'b0; mem_rdata[0] = '0; #1;
        chk("t4_last_if_rvalid", 32'(if_rvalid[0]), 32'd1);
        chk("t4_last_if_rdata", if_rdata[0], 32'hB000_0013);
        chk("t4_conf_cnt", conf_cnt[0], PERF ? 32'd10 : 32'd0);

        // back-to-back loads, MEM_LAT=2
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dm_req[1] = (i < 9); dm_we[1] = 1'b0;
            dm_addr[1] = 32'h1000 + 32'(4 * (i / 3));
            mem_rdata[1] = 32'hA000_0000 + 32'(i); #1;
            chk("t5_dm_gnt", 32'(dm_gnt[1]), 32'((i % 3 == 0) && (i < 9)));
            chk("t5_dm_rvalid", 32'(dm_rvalid[1]), 32'((i % 3 == 0) && (i > 0)));
            chk("t5_mem_en", 32'(mem_en[1]), 32'(i % 3 != 0));
            chk("t5_stall_dm", 32'(stall_dm[1]), 32'((i < 9) && !((i % 3 == 0) && (i > 0))));
            if ((i % 3 == 0) && (i > 0))
                chk("t5_dm_rdata", dm_rdata[1], 32'hA000_0000 + 32'(i - 1));
            if (i % 3 != 0)
                chk("t5_mem_addr", mem_addr[1], 32'h1000 + 32'(4 * (i / 3)));
        end

        // contention counter, MEM_LAT=2: contention in IDLE only on grant cycles 0,3,6,9
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if_req[1] = 1'b1; dm_req[1] = 1'b1; if_addr[1] = 32'h2100; dm_addr[1] = 32'h2000; #1;
            chk("t6_dm_gnt", 32'(dm_gnt[1]), 32'(i % 3 == 0));
            chk("t6_if_gnt", 32'(if_gnt[1]), 32'd0);
            chk("t6_stall_if", 32'(stall_if[1]), 32'd1);
        end
        @(negedge clk); if_req[1] = 1'b0; dm_req[1] = 1'b0; #1;
        chk("t6_conf_cnt", conf_cnt[1], PERF ? 32'd4 : 32'd0);

        // full load then reset mid-access, MEM_LAT=3
        @(negedge clk); dm_req[2] = 1'b1; dm_addr[2] = 32'h80; #1;
        chk("t1_gnt_a", 32'(dm_gnt[2]), 32'd1);
        @(negedge clk); dm_req[2] = 1'b0; #1;
        chk("t1_mem_en_a1", 32'(mem_en[2]), 32'd1);
        @(negedge clk); #1;
        chk("t1_mem_en_a2", 32'(mem_en[2]), 32'd1);
        @(negedge clk); mem_rdata[2] = 32'hCAFE_F00D; #1;
        chk("t1_mem_en_a3", 32'(mem_en[2]), 32'd1);
        chk("t1_no_early_rvalid", 32'(dm_rvalid[2]), 32'd0);
        @(negedge clk); mem_rdata[2] = '0; #1;
        chk("t1_rvalid_a", 32'(dm_rvalid[2]), 32'd1);
        chk("t1_rdata_a", dm_rdata[2], 32'hCAFE_F00D);
        chk("t1_mem_en_a_done", 32'(mem_en[2]), 32'd0);
        @(negedge clk); dm_req[2] = 1'b1; dm_addr[2] = 32'h84; #1;
        chk("t1_gnt_b", 32'(dm_gnt[2]), 32'd1);
        @(negedge clk); dm_req[2] = 1'b0; #1;
        @(negedge clk); mem_rdata[2] = 32'h5555_AAAA; #1;
        chk("t1_mem_addr_b2", mem_addr[2], 32'h84);
        rst_n[2] = 1'b0; #1;
        chk("t1_rst_mem_en", 32'(mem_en[2]), 32'd0);
        chk("t1_rst_mem_addr", mem_addr[2], 32'd0);
        chk("t1_rst_mem_be", 32'(mem_be[2]), 32'd0);
        chk("t1_rst_dm_rdata", dm_rdata[2], 32'd0);
        chk("t1_rst_dm_rvalid", 32'(dm_rvalid[2]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) rst_n[2] = 1'b1;
            #1;
            chk("t1_post_rst_rvalid", 32'(dm_rvalid[2]), 32'd0);
            chk("t1_post_rst_mem_en", 32'(mem_en[2]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
